div_issue_ctrl: RTL and testbench

//  EX-stage issue/completion controller sitting directly upstream of the multi-cycle divider.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_issue_ctrl_if.sv | 37 +++
 rtl/div_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/completion controller.
package div_pkg;

    localparam int unsigned        DIV_W       = 32;
    localparam logic [DIV_W-1:0]   DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX-side and divider-side signals of the divide issue controller.
interface div_issue_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  ex_div_valid;
    logic                  ex_div_signed;
    logic [DATA_W-1:0]     ex_src_a;
    logic [DATA_W-1:0]     ex_src_b;
    logic                  ex_flush;
    logic                  div_stall;
    logic                  hilo_we;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  div_ena;
    logic                  div_signed;
    logic [DATA_W-1:0]     div_a;
    logic [DATA_W-1:0]     div_b;
    logic [2*DATA_W-1:0]   div_res;
    logic                  div_ready;

    // Controller side.
    modport slave (
        input  ex_div_valid, ex_div_signed, ex_src_a, ex_src_b, ex_flush,
        input  div_res, div_ready,
        output div_stall, hilo_we, hi_o, lo_o,
        output div_ena, div_signed, div_a, div_b
    );

    // Pipeline plus divider side.
    modport master (
        output ex_div_valid, ex_div_signed, ex_src_a, ex_src_b, ex_flush,
        output div_res, div_ready,
        input  div_stall, hilo_we, hi_o, lo_o,
        input  div_ena, div_signed, div_a, div_b
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/completion controller for the multi-cycle divider.
// Optional BUSY watchdog enabled by defining DIV_WATCHDOG_EN.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W
`ifdef DIV_WATCHDOG_EN
    , parameter int unsigned WDOG_LIMIT = 40
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    div_issue_ctrl_if.slave   bus,
    output logic              wdog_err
);

    localparam logic [DATA_W-1:0] ZERO_LO =
        (DATA_W == DIV_W) ? DATA_W'(DIV_ZERO_LO) : '1;

    div_state_t          r_state;
    logic                r_hilo_we;
    logic                r_div_ena;
    logic                r_div_signed;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                w_accept;
    logic                w_wdog_expire;

    assign w_accept = (r_state == DIV_IDLE) && bus.ex_div_valid && !bus.ex_flush;

    // Issue FSM; flush beats a same-cycle ready, ready beats the watchdog.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= DIV_IDLE;
            r_hilo_we    <= 1'b0;
            r_div_ena    <= 1'b0;
            r_div_signed <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_a          <= '0;
            r_b          <= '0;
        end else begin
            r_hilo_we <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_a          <= bus.ex_src_a;
                        r_b          <= bus.ex_src_b;
                        r_div_signed <= bus.ex_div_signed;
                        if (bus.ex_src_b == '0) begin
                            r_hi      <= bus.ex_src_a;
                            r_lo      <= ZERO_LO;
                            r_hilo_we <= 1'b1;
                            r_state   <= DIV_DONE;
                        end else begin
                            r_div_ena <= 1'b1;
                            r_state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (bus.ex_flush) begin
                        r_div_ena <= 1'b0;
                        r_state   <= DIV_IDLE;
                    end else if (bus.div_ready) begin
                        r_hi      <= bus.div_res[2*DATA_W-1:DATA_W];
                        r_lo      <= bus.div_res[DATA_W-1:0];
                        r_hilo_we <= 1'b1;
                        r_div_ena <= 1'b0;
                        r_state   <= DIV_DONE;
                    end else if (w_wdog_expire) begin
                        r_hi      <= '0;
                        r_lo      <= '0;
                        r_hilo_we <= 1'b1;
                        r_div_ena <= 1'b0;
                        r_state   <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_div_ena <= 1'b0;
                    r_state   <= DIV_IDLE;
                end
            endcase
        end
    end

`ifdef DIV_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_err;

    assign w_wdog_expire = (r_state == DIV_BUSY) &&
                           (r_wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

    // Saturating BUSY-cycle counter and sticky expiry flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wdog_cnt <= '0;
            end else if ((r_state == DIV_BUSY) && (r_wdog_cnt != WDOG_W'(WDOG_LIMIT))) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end
            if (w_wdog_expire && !bus.ex_flush && !bus.div_ready) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wdog_expire = 1'b0;
    assign wdog_err      = 1'b0;
`endif

    assign bus.div_stall  = w_accept || (r_state == DIV_BUSY);
    // A flush arriving in the retire cycle must still squash the HI/LO write.
    assign bus.hilo_we    = r_hilo_we && !bus.ex_flush;
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;
    assign bus.div_ena    = r_div_ena;
    assign bus.div_signed = r_div_signed;
    assign bus.div_a      = r_a;
    assign bus.div_b      = r_b;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a 17-cycle behavioural divider model.
module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int unsigned W         = DIV_W;
    localparam int          MODEL_LAT = 17;
    localparam int          WDOG_LIM  = 40;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic wdog_err;

    div_issue_ctrl_if #(.DATA_W(W)) bus();

    div_issue_ctrl #(.DATA_W(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus.slave),
        .wdog_err (wdog_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: ready in the 17th enabled cycle, cleared when enable drops.
    int   m_cnt = 0;
    logic m_ready = 1'b0;
    logic never_ready = 1'b0;
    logic stale_ready = 1'b0;
    logic [W-1:0] m_q, m_r;

    always @(posedge clk) begin
        if (!bus.div_ena) begin
            m_cnt   <= 0;
            m_ready <= 1'b0;
        end else begin
            if (m_cnt < 63) m_cnt <= m_cnt + 1;
            m_ready <= !never_ready && (m_cnt >= MODEL_LAT - 2);
        end
    end

    always @* begin
        m_q = '0;
        m_r = '0;
        if (bus.div_b != '0) begin
            if (bus.div_signed) begin
                m_q = W'($signed(bus.div_a) / $signed(bus.div_b));
                m_r = W'($signed(bus.div_a) % $signed(bus.div_b));
            end else begin
                m_q = bus.div_a / bus.div_b;
                m_r = bus.div_a % bus.div_b;
            end
        end
    end

    assign bus.div_res   = {m_r, m_q};
    assign bus.div_ready = m_ready | stale_ready;

    // Scoreboard of expected HI/LO writes.
    typedef struct packed { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (resetn && bus.hilo_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_hilo_we", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("hi_o", 64'(bus.hi_o), 64'(mon_e.hi));
                chk("lo_o", 64'(bus.lo_o), 64'(mon_e.lo));
            end
        end
    end

    // Length of the most recent div_ena-low gap.
    int ena_gap = 0;
    int last_gap = -1;
    always @(negedge clk) begin
        if (bus.div_ena) begin
            if (ena_gap > 0) last_gap = ena_gap;
            ena_gap = 0;
        end else begin
            ena_gap++;
        end
    end

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[7];

    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input int exp_stalls);
        int  stalls;
        bit  done;
        exp_t e;
        @(posedge clk); #1;
        bus.ex_div_valid  = 1'b1;
        bus.ex_div_signed = sgn;
        bus.ex_src_a      = a;
        bus.ex_src_b      = b;
        e.hi = hi;
        e.lo = lo;
        sb.push_back(e);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.hilo_we) begin
                done = 1'b1;
                chk("done_stall", 64'(bus.div_stall), 64'd0);
                chk("done_ena", 64'(bus.div_ena), 64'd0);
            end else begin
                if (bus.div_stall) stalls++;
                if (bus.div_ena) begin
                    chk("busy_signed", 64'(bus.div_signed), 64'(sgn));
                    chk("busy_a", 64'(bus.div_a), 64'(a));
                    chk("busy_b", 64'(bus.div_b), 64'(b));
                    if (b == '0) chk("zero_div_ena", 64'd1, 64'd0);
                end
            end
        end
        chk("op_done_timeout", 64'(done), 64'd1);
        chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.ex_div_valid = 1'b0;
            bus.ex_flush     = 1'b0;
        end
    endtask

    task automatic flush_at(input int busy_cycle);
        @(posedge clk); #1;
        bus.ex_div_valid  = 1'b1;
        bus.ex_div_signed = 1'b0;
        bus.ex_src_a      = 32'd1000;
        bus.ex_src_b      = 32'd3;
        @(negedge clk);
        chk("flush_accept_stall", 64'(bus.div_stall), 64'd1);
        repeat (busy_cycle) @(posedge clk);
        #1 bus.ex_flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_ena", 64'(bus.div_ena), 64'd1);
        @(posedge clk); #1;
        bus.ex_flush     = 1'b0;
        bus.ex_div_valid = 1'b0;
        @(negedge clk);
        chk("flush_ena_drop", 64'(bus.div_ena), 64'd0);
        chk("flush_stall_drop", 64'(bus.div_stall), 64'd0);
        repeat (25) @(negedge clk);
        chk("flush_stays_idle", 64'(bus.div_ena), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_stall"},  64'(bus.div_stall), 64'd0);
        chk({tag, "_hilo_we"}, 64'(bus.hilo_we), 64'd0);
        chk({tag, "_hi"},     64'(bus.hi_o), 64'd0);
        chk({tag, "_lo"},     64'(bus.lo_o), 64'd0);
        chk({tag, "_ena"},    64'(bus.div_ena), 64'd0);
        chk({tag, "_signed"}, 64'(bus.div_signed), 64'd0);
        chk({tag, "_a"},      64'(bus.div_a), 64'd0);
        chk({tag, "_b"},      64'(bus.div_b), 64'd0);
        chk({tag, "_wdog"},   64'(wdog_err), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd2,        32'd14};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2] = '{1'b0, 32'd5,          32'd0,        32'd5,        32'hFFFF_FFFF};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'd0,        32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFF2};
        vecs[5] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 32'h1234_5678,  32'd1000,     32'h0000_0380, 32'h0004_A90B};

        bus.ex_div_valid  = 1'b0;
        bus.ex_div_signed = 1'b0;
        bus.ex_src_a      = '0;
        bus.ex_src_b      = '0;
        bus.ex_flush      = 1'b0;
        resetn            = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1 resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   (vecs[i].b == '0) ? 1 : MODEL_LAT + 1);
            idle(2);
        end

        // Back-to-back: second op issued in the IDLE cycle following DONE.
        run_op(vecs[0].sgn, vecs[0].a, vecs[0].b, vecs[0].hi, vecs[0].lo, MODEL_LAT + 1);
        run_op(vecs[1].sgn, vecs[1].a, vecs[1].b, vecs[1].hi, vecs[1].lo, MODEL_LAT + 1);
        idle(1);
        chk("b2b_ena_gap", 64'(last_gap), 64'd2);

        flush_at(6);
        flush_at(MODEL_LAT);

        // Flush in IDLE blocks acceptance.
        @(posedge clk); #1;
        bus.ex_div_valid = 1'b1;
        bus.ex_src_b     = 32'd3;
        bus.ex_flush     = 1'b1;
        @(negedge clk);
        chk("idle_flush_stall", 64'(bus.div_stall), 64'd0);
        idle(1);
        @(negedge clk);
        chk("idle_flush_no_ena", 64'(bus.div_ena), 64'd0);

        // Stale ready outside BUSY must be ignored.
        @(posedge clk); #1 stale_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stale_ready_ena", 64'(bus.div_ena), 64'd0);
            chk("stale_ready_we", 64'(bus.hilo_we), 64'd0);
        end
        @(posedge clk); #1 stale_ready = 1'b0;

        // Flush in the DONE cycle of a divide-by-zero squashes the write.
        @(posedge clk); #1;
        bus.ex_div_valid  = 1'b1;
        bus.ex_div_signed = 1'b0;
        bus.ex_src_a      = 32'd5;
        bus.ex_src_b      = 32'd0;
        @(posedge clk); #1 bus.ex_flush = 1'b1;
        @(negedge clk);
        chk("done_flush_we", 64'(bus.hilo_we), 64'd0);
        idle(2);

        // Asynchronous reset in the middle of BUSY.
        @(posedge clk); #1;
        bus.ex_div_valid  = 1'b1;
        bus.ex_div_signed = 1'b1;
        bus.ex_src_a      = 32'd100;
        bus.ex_src_b      = 32'd7;
        repeat (6) @(posedge clk);
        #3;
        chk("pre_reset_ena", 64'(bus.div_ena), 64'd1);
        resetn           = 1'b0;
        bus.ex_div_valid = 1'b0;
        #1;
        chk_reset_outputs("midbusy_reset");
        @(posedge clk); #1 resetn = 1'b1;
        repeat (25) @(negedge clk);
        chk("post_reset_idle", 64'(bus.div_ena), 64'd0);

`ifdef DIV_WATCHDOG_EN
        never_ready = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, 32'd0, 32'd0, WDOG_LIM + 1);
        chk("wdog_err_set", 64'(wdog_err), 64'd1);
        idle(3);
        chk("wdog_err_sticky", 64'(wdog_err), 64'd1);
        never_ready = 1'b0;
`else
        chk("wdog_err_tied", 64'(wdog_err), 64'd0);
`endif

        idle(2);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
